// File: rtl/alu_pkg.sv
// Opcodes shared by the execute-stage ALU, decode and the multiply/divide unit,
// plus the multiply/divide controller state type.
package alu_pkg;

    localparam logic [3:0] SUM         = 4'b0000;
    localparam logic [3:0] SUBTRACT    = 4'b0001;
    localparam logic [3:0] MULTIPLY    = 4'b0010;
    localparam logic [3:0] DIVIDE      = 4'b0011;
    localparam logic [3:0] BITWISE_NOT = 4'b0110;
    localparam logic [3:0] EQUAL       = 4'b1010;
    localparam logic [3:0] DIFFERENT   = 4'b1011;
    localparam logic [3:0] GREATER     = 4'b1100;
    localparam logic [3:0] LESS        = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        DONE = 2'b11
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiplier (shift-add) / divider (restoring), one step per
// clock, with a start/done handshake and registered results on lo/hi.
module muldiv_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       sel,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    muldiv_state_t    state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   rem_q;   // multiply: accumulator upper half; divide: partial remainder
    logic [WIDTH-1:0] quo_q;   // multiply: accumulator lower half; divide: quotient
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] lo_q, hi_q;
    logic             busy_q, done_q, dbz_q;

    logic             is_mul;
    logic             last;
    logic             accept;
    logic [WIDTH:0]   add_a;
    logic [WIDTH+1:0] addsub;
    logic [WIDTH:0]   upper;
    logic [WIDTH:0]   rem_d;
    logic [WIDTH-1:0] quo_d;

    // Single adder: plain add for multiply, subtract (invert + carry-in) for divide.
    always_comb begin
        is_mul = (state_q == MUL);
        add_a  = is_mul ? {1'b0, rem_q[WIDTH-1:0]} : {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        addsub = {1'b0, add_a}
               + (is_mul ? {2'b00, opb_q} : ~{2'b00, opb_q})
               + {{(WIDTH+1){1'b0}}, ~is_mul};
        upper  = quo_q[0] ? addsub[WIDTH:0] : {1'b0, rem_q[WIDTH-1:0]};
        rem_d  = rem_q;
        quo_d  = quo_q;
        if (is_mul) begin
            rem_d = {1'b0, upper[WIDTH:1]};
            quo_d = {upper[0], quo_q[WIDTH-1:1]};
        end else if (addsub[WIDTH+1]) begin
            rem_d = add_a;
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end else begin
            rem_d = addsub[WIDTH:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end
        last   = (cnt_q == CW'(WIDTH - 1));
        accept = start && (sel == MULTIPLY || sel == DIVIDE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            opb_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        cnt_q <= '0;
                        opb_q <= op2;
                        quo_q <= op1;
                        rem_q <= '0;
                        if (sel == DIVIDE && op2 == '0) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            dbz_q   <= 1'b1;
                            lo_q    <= '1;
                            hi_q    <= op1;
                        end else begin
                            state_q <= (sel == MULTIPLY) ? MUL : DIV;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                            dbz_q   <= 1'b0;
                        end
                    end else begin
                        if (state_q == DONE) state_q <= IDLE;
                        done_q <= 1'b0;
                    end
                end
                MUL, DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        lo_q    <= quo_d;
                        hi_q    <= rem_d[WIDTH-1:0];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign lo          = lo_q;
    assign hi          = hi_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised and directed check of muldiv_unit against a plain-arithmetic
// model of multiply, divide and divide-by-zero results and handshake timing.
module tb_muldiv_unit;
    import alu_pkg::*;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [3:0]   sel;
    logic [W-1:0] op1, op2;
    logic         busy, done, div_by_zero;
    logic [W-1:0] lo, hi;

    int checks   = 0;
    int failures = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .sel         (sel),
        .op1         (op1),
        .op2         (op2),
        .busy        (busy),
        .done        (done),
        .lo          (lo),
        .hi          (hi),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; issues one operation and waits for its done pulse.
    // pulse10 injects an extra start mid-operation; chain leaves the unit in DONE.
    task automatic do_op(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit pulse10, input bit chain);
        logic [63:0] exp_lo, exp_hi;
        logic        exp_dbz;
        int          n, busy_cnt, exp_lat;
        if (s == MULTIPLY) begin
            exp_lo  = 64'(a) * 64'(b) & 64'hFFFF_FFFF;
            exp_hi  = (64'(a) * 64'(b)) >> 32;
            exp_dbz = 1'b0;
        end else if (b == 0) begin
            exp_lo  = 64'hFFFF_FFFF;
            exp_hi  = 64'(a);
            exp_dbz = 1'b1;
        end else begin
            exp_lo  = 64'(a / b);
            exp_hi  = 64'(a % b);
            exp_dbz = 1'b0;
        end
        exp_lat = exp_dbz ? 0 : W;
        start = 1'b1; sel = s; op1 = a; op2 = b;
        @(negedge clk);
        start = 1'b0;
        n = 0; busy_cnt = 0;
        while (!done && n < 200) begin
            if (busy) busy_cnt++;
            if (pulse10 && n == 10) begin
                start = 1'b1; sel = DIVIDE; op1 = 32'h55; op2 = '0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("latency", 64'(n), 64'(exp_lat));
        chk("busy_cycles", 64'(busy_cnt), 64'(exp_lat));
        chk("done", 64'(done), 64'd1);
        chk("busy_at_done", 64'(busy), 64'd0);
        chk("lo", 64'(lo), exp_lo);
        chk("hi", 64'(hi), exp_hi);
        chk("div_by_zero", 64'(div_by_zero), 64'(exp_dbz));
        if (!chain) begin
            @(negedge clk);
            chk("done_pulse_width", 64'(done), 64'd0);
            chk("lo_held", 64'(lo), exp_lo);
            chk("hi_held", 64'(hi), exp_hi);
        end
    endtask

    initial begin
        logic [W-1:0] a, b, keep_lo, keep_hi;
        logic [3:0]   s;
        rst_n = 1'b0; start = 1'b0; sel = SUM; op1 = '0; op2 = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_dbz", 64'(div_by_zero), 64'd0);
        rst_n = 1'b1;

        do_op(MULTIPLY, 32'd7, 32'd6, 1'b0, 1'b0);
        do_op(MULTIPLY, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op(DIVIDE, 32'd100, 32'd7, 1'b0, 1'b0);
        do_op(DIVIDE, 32'd5, 32'd9, 1'b0, 1'b0);
        do_op(DIVIDE, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        do_op(DIVIDE, 32'd1234, 32'd0, 1'b0, 1'b0);
        do_op(MULTIPLY, 32'd2, 32'd3, 1'b0, 1'b0);

        keep_lo = lo; keep_hi = hi;
        start = 1'b1; sel = SUM; op1 = 32'd9; op2 = 32'd9;
        repeat (3) begin
            @(negedge clk);
            chk("ignored_busy", 64'(busy), 64'd0);
            chk("ignored_done", 64'(done), 64'd0);
            chk("ignored_lo", 64'(lo), 64'(keep_lo));
        end
        start = 1'b0;

        do_op(MULTIPLY, 32'd1000, 32'd3000, 1'b1, 1'b0);
        do_op(MULTIPLY, 32'd123, 32'd456, 1'b0, 1'b1);
        do_op(DIVIDE, 32'd999, 32'd10, 1'b0, 1'b1);
        do_op(DIVIDE, 32'd77, 32'd0, 1'b0, 1'b1);
        do_op(MULTIPLY, 32'd11, 32'd13, 1'b0, 1'b0);

        start = 1'b1; sel = DIVIDE; op1 = 32'd5000; op2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_done", 64'(done), 64'd0);
        chk("async_rst_lo", 64'(lo), 64'd0);
        chk("async_rst_hi", 64'(hi), 64'd0);
        chk("async_rst_dbz", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            chk("no_done_after_abort", 64'(done), 64'd0);
        end
        do_op(MULTIPLY, 32'd9, 32'd9, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            s = ($urandom_range(0, 1) == 0) ? MULTIPLY : DIVIDE;
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = '0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            do_op(s, a, b, 1'b0, ($urandom_range(0, 2) == 0));
        end
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
